// File: rtl/run_scan_ctrl_if.sv
// Word/result handshake bundle for run_scan_ctrl.
// master = producer/consumer side, slave = the scan controller.
interface run_scan_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_ones;
    logic [CW-1:0]    out_zeros;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_ones,
        input  out_zeros
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_ones,
        output out_zeros
    );
endinterface

// File: rtl/run_scan_ctrl.sv
// Word-level sequencer: shifts an accepted word MSB-first through a run-of-equal-bits
// detector and reports per-polarity tick counts. PATDET_CARRY_EN keeps the run tracker across words.
module run_scan_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned RUN_LEN = 4
) (
    input  logic            clk,
    input  logic            reset,
    run_scan_ctrl_if.slave  bus,
    output logic            bit_o,
    output logic            tick_o
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned KW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(RUN_LEN + 1);

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("run_scan_ctrl: WIDTH out of range 4..32");
    end
    if (RUN_LEN < 2 || RUN_LEN > WIDTH) begin : g_bad_run_len
        $error("run_scan_ctrl: RUN_LEN out of range 2..WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] word_q, word_nxt;
    logic [KW-1:0]    k_q, k_nxt;
    logic [CW-1:0]    ones_q, ones_nxt;
    logic [CW-1:0]    zeros_q, zeros_nxt;
    logic             last_q, last_nxt;
    logic [RW-1:0]    run_q, run_nxt;
    logic [RW-1:0]    run_cand;
    logic             in_ready_q;
    logic             out_valid_q;

    // Next-state, datapath update and detector outputs
    always_comb begin
        state_nxt = state;
        word_nxt  = word_q;
        k_nxt     = k_q;
        ones_nxt  = ones_q;
        zeros_nxt = zeros_q;
        last_nxt  = last_q;
        run_nxt   = run_q;
        run_cand  = RW'(1);
        bit_o     = 1'b0;
        tick_o    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    word_nxt  = bus.in_data;
                    k_nxt     = '0;
                    ones_nxt  = '0;
                    zeros_nxt = '0;
`ifndef PATDET_CARRY_EN
                    last_nxt  = 1'b0;
                    run_nxt   = '0;
`endif
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bit_o = word_q[WIDTH-1];
                // Saturate at RUN_LEN so every further equal bit ticks again
                if (run_q != '0 && bit_o == last_q) begin
                    run_cand = (run_q == RW'(RUN_LEN)) ? RW'(RUN_LEN) : run_q + RW'(1);
                end
                tick_o   = (run_cand == RW'(RUN_LEN));
                last_nxt = bit_o;
                run_nxt  = run_cand;
                if (tick_o) begin
                    if (bit_o) ones_nxt  = ones_q + CW'(1);
                    else       zeros_nxt = zeros_q + CW'(1);
                end
                word_nxt = {word_q[WIDTH-2:0], 1'b0};
                k_nxt    = k_q + KW'(1);
                if (k_q == KW'(WIDTH - 1)) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; handshake flags registered from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            word_q      <= '0;
            k_q         <= '0;
            ones_q      <= '0;
            zeros_q     <= '0;
            last_q      <= 1'b0;
            run_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            word_q      <= word_nxt;
            k_q         <= k_nxt;
            ones_q      <= ones_nxt;
            zeros_q     <= zeros_nxt;
            last_q      <= last_nxt;
            run_q       <= run_nxt;
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == REPORT);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ones  = ones_q;
    assign bus.out_zeros = zeros_q;
endmodule

// File: tb/tb_run_scan_ctrl.sv
// Directed self-checking bench for run_scan_ctrl (WIDTH=8, RUN_LEN=4).
// Expected counts and tick positions are hand-derived per word.
module tb_run_scan_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic bit_o;
    logic tick_o;
    int   errors = 0;
    int   checks = 0;

    run_scan_ctrl_if #(.WIDTH(8)) bus ();

    run_scan_ctrl #(.WIDTH(8), .RUN_LEN(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .bit_o  (bit_o),
        .tick_o (tick_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One word: accept, WIDTH shift cycles, REPORT held for 'hold' cycles, then release
    task automatic scan(input logic [7:0] w, input int hold, input logic [7:0] tmask,
                        input logic [3:0] eo, input logic [3:0] ez, input logic bp_valid);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = ~w;
        for (int k = 0; k < 8; k++) begin
            chk("shift_in_ready", 32'(bus.in_ready), 32'd0);
            chk("shift_out_valid", 32'(bus.out_valid), 32'd0);
            chk("shift_bit_o", 32'(bit_o), 32'(w[7-k]));
            chk("shift_tick_o", 32'(tick_o), 32'(tmask[k]));
            step();
        end
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            if (bp_valid) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'h0F;
            end
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_ones", 32'(bus.out_ones), 32'(eo));
            chk("bp_zeros", 32'(bus.out_zeros), 32'(ez));
            chk("bp_bit_o", 32'(bit_o), 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        chk("rep_out_valid", 32'(bus.out_valid), 32'd1);
        chk("rep_ones", 32'(bus.out_ones), 32'(eo));
        chk("rep_zeros", 32'(bus.out_zeros), 32'(ez));
        chk("rep_tick_o", 32'(tick_o), 32'd0);
        step();
        bus.out_ready = 1'b0;
        chk("post_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_reset(input logic iv);
        reset        = 1'b1;
        bus.in_valid = iv;
        bus.in_data  = 8'hFF;
        step();
        step();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset with in_valid asserted: nothing accepted
        do_reset(1'b1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ones", 32'(bus.out_ones), 32'd0);
        chk("rst_zeros", 32'(bus.out_zeros), 32'd0);
        chk("rst_bit_o", 32'(bit_o), 32'd0);
        chk("rst_tick_o", 32'(tick_o), 32'd0);
        step();
        chk("rst_not_accepted", 32'(bus.in_ready), 32'd1);

        // Basic, saturation, alternating, backpressure
        scan(8'hF0, 0, 8'h88, 4'd1, 4'd0 + 4'd1, 1'b0);
        scan(8'hFF, 0, 8'hF8, 4'd5, 4'd0, 1'b0);
        scan(8'h00, 0, 8'hF8, 4'd0, 4'd5, 1'b0);
        scan(8'hAA, 0, 8'h00, 4'd0, 4'd0, 1'b0);
        scan(8'hF0, 3, 8'h88, 4'd1, 4'd1, 1'b1);

        // Word boundary: fresh tracker then 0x0F, 0xF0
        do_reset(1'b0);
        scan(8'h0F, 0, 8'h88, 4'd1, 4'd1, 1'b0);
`ifdef PATDET_CARRY_EN
        scan(8'hF0, 0, 8'h8F, 4'd4, 4'd1, 1'b0);
`else
        scan(8'hF0, 0, 8'h88, 4'd1, 4'd1, 1'b0);
`endif

        // Reset during SHIFT at k=5 of 0xFF
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("mid_bit_o_k5", 32'(bit_o), 32'd1);
        chk("mid_tick_o_k5", 32'(tick_o), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ones", 32'(bus.out_ones), 32'd0);
        chk("mid_rst_bit_o", 32'(bit_o), 32'd0);
        for (int c = 0; c < 10; c++) begin
            chk("mid_no_out_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        scan(8'h00, 0, 8'hF8, 4'd0, 4'd5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
